hazard_controller: RTL

//  Pipeline stall/flush sequencer for the 5-stage RISC-V core, partner to the EX-stage operand-forwarding logic.

---
 rtl/hazard_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush sequencer: load-use bubble, branch flush, MDU freeze with watchdog
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module hazard_controller #(
   parameter int MDU_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs1_id,
   input  logic [4:0] rs2_id,
   input  logic [4:0] rd_ex,
   input  logic       MemRead_ex,
   input  logic       branch_taken_ex,
   input  logic       mdu_start_ex,
   input  logic       mdu_done,
   output logic       stall_if,
   output logic       stall_id,
   output logic       stall_ex,
   output logic       flush_id,
   output logic       flush_ex,
   output logic       mdu_busy,
   output logic       mdu_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   localparam int WDOG_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MDU_TIMEOUT - 1);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic                mdu_timeout_q, mdu_timeout_d;

   logic load_use;
   logic stall_if_c, stall_id_c, stall_ex_c, flush_id_c, flush_ex_c;

   assign load_use = MemRead_ex && (rd_ex != 5'd0) &&
                     ((rd_ex == rs1_id) || (rd_ex == rs2_id));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         wdog_q        <= '0;
         mdu_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wdog_q        <= wdog_d;
         mdu_timeout_q <= mdu_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      mdu_timeout_d = mdu_timeout_q;
      stall_if_c    = 1'b0;
      stall_id_c    = 1'b0;
      stall_ex_c    = 1'b0;
      flush_id_c    = 1'b0;
      flush_ex_c    = 1'b0;
      case (state_q)
         RUN: begin
            if (branch_taken_ex) begin
               flush_id_c = 1'b1;
               flush_ex_c = 1'b1;
            end else if (mdu_start_ex) begin
               // A done pulse coinciding with start belongs to no op of ours; always wait at least one cycle.
               stall_if_c = 1'b1;
               stall_id_c = 1'b1;
               stall_ex_c = 1'b1;
               state_d    = MDU_WAIT;
               wdog_d     = '0;
            end else if (load_use) begin
               stall_if_c = 1'b1;
               stall_id_c = 1'b1;
               flush_ex_c = 1'b1;
            end
         end
         MDU_WAIT: begin
            if (mdu_done) begin
               state_d = RUN;
               wdog_d  = '0;
            end else if (wdog_q == WDOG_LAST) begin
               state_d       = RUN;
               wdog_d        = '0;
               mdu_timeout_d = 1'b1;
            end else begin
               stall_if_c = 1'b1;
               stall_id_c = 1'b1;
               stall_ex_c = 1'b1;
               wdog_d     = wdog_q + WDOG_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Gate with rst so the pipeline sees no stall/flush while reset is held, whatever the inputs do.
   assign stall_if    = stall_if_c & ~rst;
   assign stall_id    = stall_id_c & ~rst;
   assign stall_ex    = stall_ex_c & ~rst;
   assign flush_id    = flush_id_c & ~rst;
   assign flush_ex    = flush_ex_c & ~rst;
   assign mdu_busy    = (state_q == MDU_WAIT) & ~rst;
   assign mdu_timeout = mdu_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (stall_if && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush_id && (flush_events_q != 32'hFFFF_FFFF))
         flush_events_d = flush_events_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule
